// File: rtl/jump_ctrl.sv
// Jump/gravity controller: turns the jump button into a per-tick height profile.
// Optional air jump enabled by defining JUMP_CTRL_DOUBLE_EN.
module jump_ctrl #(
  parameter int WIDTH      = 10,
  parameter int MAX_HEIGHT = 100,
  parameter int V0         = 16,
  parameter int GRAVITY    = 2,
  parameter int VMAX       = 16,
  parameter int CUT_VEL    = 4,
  parameter int COOLDOWN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             jump_btn,
  output logic [WIDTH-1:0] height,
  output logic             airborne,
  output logic             rising,
  output logic             landed
);

  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN);
  localparam logic [WIDTH:0]   MAXH_X = (WIDTH+1)'(MAX_HEIGHT);
  localparam logic [WIDTH-1:0] MAXH_W = WIDTH'(MAX_HEIGHT);
  localparam logic [WIDTH-1:0] V0_W   = WIDTH'(V0);
  localparam logic [WIDTH-1:0] G_W    = WIDTH'(GRAVITY);
  localparam logic [WIDTH:0]   G_X    = (WIDTH+1)'(GRAVITY);
  localparam logic [WIDTH:0]   VMAX_X = (WIDTH+1)'(VMAX);
  localparam logic [WIDTH-1:0] VMAX_W = WIDTH'(VMAX);
  localparam logic [WIDTH-1:0] CUT_W  = WIDTH'(CUT_VEL);
  localparam logic [CW-1:0]    CD_END = CW'(COOLDOWN - 1);

  typedef enum logic [1:0] {IDLE, RISE, FALL, LAND} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] vel, vel_nx, height_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             btn_q, pending, press, go, land_nx;
  logic [WIDTH:0]   sum, vfall;

  // A press on the same clk as the tick counts toward that tick.
  assign press = jump_btn & ~btn_q;
  assign go    = pending | press;
  assign sum   = {1'b0, height} + {1'b0, vel};
  assign vfall = {1'b0, vel} + G_X;

`ifdef JUMP_CTRL_DOUBLE_EN
  logic used, used_nx;
`endif

  always_comb begin
    state_nx  = state;
    height_nx = height;
    vel_nx    = vel;
    cnt_nx    = cnt;
    land_nx   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: if (go) begin
          state_nx = RISE;
          vel_nx   = V0_W;
        end
        RISE: begin
          if (sum >= MAXH_X) begin
            height_nx = MAXH_W;
            vel_nx    = '0;
            state_nx  = FALL;
          end else begin
            height_nx = sum[WIDTH-1:0];
            if (vel <= G_W) begin
              vel_nx   = '0;
              state_nx = FALL;
            end else begin
              vel_nx = vel - G_W;
            end
          end
          // Early release caps the remaining rise.
          if (!jump_btn && vel_nx > CUT_W) vel_nx = CUT_W;
        end
        FALL: begin
          if (height <= vel) begin
            height_nx = '0;
            vel_nx    = '0;
            cnt_nx    = '0;
            state_nx  = LAND;
            land_nx   = 1'b1;
          end else begin
            height_nx = height - vel;
            vel_nx    = (vfall > VMAX_X) ? VMAX_W : vfall[WIDTH-1:0];
          end
        end
        LAND: begin
          if (cnt == CD_END) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
`ifdef JUMP_CTRL_DOUBLE_EN
    used_nx = used;
    if (tick && go && !used && (state == RISE || state == FALL)) begin
      state_nx  = RISE;
      vel_nx    = V0_W;
      height_nx = height;
      land_nx   = 1'b0;
      used_nx   = 1'b1;
    end
    if (land_nx) used_nx = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      height  <= '0;
      vel     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      btn_q   <= 1'b0;
      landed  <= 1'b0;
    end else begin
      state   <= state_nx;
      height  <= height_nx;
      vel     <= vel_nx;
      cnt     <= cnt_nx;
      btn_q   <= jump_btn;
      landed  <= land_nx;
      // Every tick consumes or discards the pending press.
      if (tick)       pending <= 1'b0;
      else if (press) pending <= 1'b1;
    end
  end

`ifdef JUMP_CTRL_DOUBLE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) used <= 1'b0;
    else       used <= used_nx;
  end
`endif

  assign airborne = (state == RISE) || (state == FALL);
  assign rising   = (state == RISE);

endmodule

// File: tb/tb_jump_ctrl.sv
// Random + directed bench for jump_ctrl; two instances (ceiling 100 and 50)
// checked against an integer trajectory model.
module tb_jump_ctrl;

  localparam int V0 = 16, G = 2, VMAX = 16, CUT = 4, COOLDOWN = 4;
`ifdef JUMP_CTRL_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic       clk, rst, tick, btn;
  logic [9:0] h0, h1;
  logic       air0, air1, ris0, ris1, lnd0, lnd1;

  jump_ctrl u_dut (
    .clk(clk), .reset(rst), .tick(tick), .jump_btn(btn),
    .height(h0), .airborne(air0), .rising(ris0), .landed(lnd0));

  jump_ctrl #(.MAX_HEIGHT(50)) u_dut50 (
    .clk(clk), .reset(rst), .tick(tick), .jump_btn(btn),
    .height(h1), .airborne(air1), .rising(ris1), .landed(lnd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 ground, 1 going up, 2 coming down, 3 cooling down.
  int maxh[2] = '{100, 50};
  int mh[2], mv[2], mmode[2], mcd[2], mused[2], mland[2];
  int mpend, mprev;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; mmode[k] = 0; mcd[k] = 0; mused[k] = 0; mland[k] = 0;
    end
    mpend = 0; mprev = 0;
  endtask

  task automatic model_step(input int t, input int b);
    int press, go;
    press = (b != 0) && (mprev == 0);
    go = mpend || press;
    for (int k = 0; k < 2; k++) begin
      mland[k] = 0;
      if (t == 0) continue;
      if (DBL && go && mused[k] == 0 && (mmode[k] == 1 || mmode[k] == 2)) begin
        mv[k] = V0; mmode[k] = 1; mused[k] = 1;
      end else if (mmode[k] == 0) begin
        if (go) begin mmode[k] = 1; mv[k] = V0; end
      end else if (mmode[k] == 1) begin
        if (mh[k] + mv[k] >= maxh[k]) begin
          mh[k] = maxh[k]; mv[k] = 0; mmode[k] = 2;
        end else begin
          mh[k] = mh[k] + mv[k];
          mv[k] = (mv[k] <= G) ? 0 : mv[k] - G;
          if (mv[k] == 0) mmode[k] = 2;
        end
        if (b == 0 && mv[k] > CUT) mv[k] = CUT;
      end else if (mmode[k] == 2) begin
        if (mh[k] <= mv[k]) begin
          mh[k] = 0; mv[k] = 0; mmode[k] = 3; mcd[k] = 0; mland[k] = 1; mused[k] = 0;
        end else begin
          mh[k] = mh[k] - mv[k];
          mv[k] = (mv[k] + G > VMAX) ? VMAX : mv[k] + G;
        end
      end else begin
        mcd[k]++;
        if (mcd[k] == COOLDOWN) mmode[k] = 0;
      end
    end
    if (t != 0) mpend = 0;
    else if (press) mpend = 1;
    mprev = b;
  endtask

  task automatic cmp_all();
    check("height",   h0,   mh[0]);
    check("airborne", air0, int'(mmode[0] == 1 || mmode[0] == 2));
    check("rising",   ris0, int'(mmode[0] == 1));
    check("landed",   lnd0, mland[0]);
    check("height50",   h1,   mh[1]);
    check("airborne50", air1, int'(mmode[1] == 1 || mmode[1] == 2));
    check("rising50",   ris1, int'(mmode[1] == 1));
    check("landed50",   lnd1, mland[1]);
  endtask

  // Drive inputs after a negedge, model the posedge, compare at the next negedge.
  task automatic cyc(input logic t, input logic b);
    tick = t; btn = b;
    @(posedge clk);
    model_step(int'(t), int'(b));
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_height", h0, 0);
    check("rst_air",    air0, 0);
    check("rst_rising", ris0, 0);
    check("rst_landed", lnd0, 0);
    check("rst_height50", h1, 0);
    #1 rst = 1'b0;
  endtask

  int held0[18] = '{0,16,30,42,52,60,66,70,72,72,70,66,60,52,42,30,16,0};
  int held1[13] = '{0,16,30,42,50,50,48,44,38,30,20,8,0};
  int rel[5]    = '{0,16,30,34,36};

  initial begin
    int saved;
    tick = 1'b0; btn = 1'b0; rst = 1'b0;
    do_reset();

    // Held jump through landing and cooldown.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, 1'b1);
      check("held_h", h0, held0[i]);
      if (i < 13) check("held_h50", h1, held1[i]);
    end
    check("landed_pulse", lnd0, 1);
    cyc(1'b0, 1'b0);
    check("landed_gone", lnd0, 0);
    cyc(1'b0, 1'b1);               // press between ticks in cooldown: lost
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);               // fourth cooldown tick -> ground
    check("land_press_ignored", ris0, 0);
    cyc(1'b1, 1'b1);
    check("idle_jump", ris0, 1);

    // Early release caps the rise.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, i < 2);
      check("release_h", h0, rel[i]);
    end
    cyc(1'b1, 1'b0);
    check("release_peak_fall", ris0, 0);

    // Reset mid-fall at 52.
    do_reset();
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1);
    check("midfall_h", h0, 52);
    check("midfall_air", air0, 1);
    do_reset();

    // Press while falling at 60.
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1);
    check("fall60_h", h0, 60);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    check("air_press_rising", ris0, DBL ? 1 : 0);
    cyc(1'b1, 1'b0);
    check("air_press_h", h0, DBL ? 76 : 42);

    // Frozen without ticks.
    do_reset();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    saved = h0;
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
    check("frozen_h", h0, saved);
    check("frozen_rising", ris0, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(1'($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0) ? ~btn : btn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
